// File: rtl/mips_defs_pkg.sv
// Shared MIPS-subset definitions: field positions, opcode/funct/ALU encodings
// and the ID/EX payload layout.
package mips_defs;

  localparam int unsigned WORD_LENGTH = 32;
  localparam int unsigned REG_COUNT   = 32;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned ALU_W       = 4;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_MSB  = 15;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned FN_MSB  = 5;
  localparam int unsigned FN_LSB  = 0;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'd4;

  localparam logic [WORD_LENGTH-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_LENGTH-1:0] pc;
    logic [WORD_LENGTH-1:0] val1;
    logic [WORD_LENGTH-1:0] val2;
    logic [WORD_LENGTH-1:0] imm_ext;
    logic [REG_AW-1:0]      dest;
    logic [ALU_W-1:0]       alu_cmd;
    logic                   imm_sel;
    logic                   mem_read;
    logic                   mem_write;
    logic                   wb_en;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one write port, r0 hardwired to zero.
module register_file
  import mips_defs::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_AW-1:0]      ra1_i,
  input  logic [REG_AW-1:0]      ra2_i,
  output logic [WORD_LENGTH-1:0] rd1_o,
  output logic [WORD_LENGTH-1:0] rd2_o,
  input  logic                   we_i,
  input  logic [REG_AW-1:0]      wa_i,
  input  logic [WORD_LENGTH-1:0] wd_i
);

  logic [WORD_LENGTH-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_COUNT); i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Same-cycle writeback is visible to the reader (write-through).
  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    if (ra1_i != '0) rd1_o = (we_i && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
    if (ra2_i != '0) rd2_o = (we_i && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, register file, control decode,
// hazard detection, branch resolution and the ID/EX register.
module id_stage
  import mips_defs::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] ifPC,
  input  logic [WORD_LENGTH-1:0] ifInstruction,
  input  logic                   wbEn,
  input  logic [REG_AW-1:0]      wbDest,
  input  logic [WORD_LENGTH-1:0] wbValue,
  input  logic                   exWbEn,
  input  logic                   exMemRead,
  input  logic [REG_AW-1:0]      exDest,
  input  logic                   memWbEn,
  input  logic                   memMemRead,
  input  logic [REG_AW-1:0]      memDest,
  output logic                   brTaken,
  output logic [WORD_LENGTH-1:0] brOffset,
  output logic                   Haz_Det,
  output logic [WORD_LENGTH-1:0] idPC,
  output logic [WORD_LENGTH-1:0] val1,
  output logic [WORD_LENGTH-1:0] val2,
  output logic [WORD_LENGTH-1:0] immExt,
  output logic [REG_AW-1:0]      dest,
  output logic [ALU_W-1:0]       aluCmd,
  output logic                   immSel,
  output logic                   memRead,
  output logic                   memWrite,
  output logic                   wbEnOut
);

  logic [WORD_LENGTH-1:0] ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d;
  logic                   ifid_valid_q, ifid_valid_d;
  idex_t                  idex_q, idex_d;

  logic [5:0]             op, funct;
  logic [REG_AW-1:0]      rs, rt, rd;
  logic [WORD_LENGTH-1:0] imm_ext, rs_val, rt_val;

  logic [ALU_W-1:0]  ctl_alu;
  logic [REG_AW-1:0] ctl_dest;
  logic ctl_imm, ctl_mr, ctl_mw, ctl_wb, known, use_rs, use_rt, is_beq, is_bne;
  logic rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic load_use_c, br_stall_c, haz_c, br_taken_c, unused_c;

  assign op      = ifid_instr_q[OP_MSB:OP_LSB];
  assign rs      = ifid_instr_q[RS_MSB:RS_LSB];
  assign rt      = ifid_instr_q[RT_MSB:RT_LSB];
  assign rd      = ifid_instr_q[RD_MSB:RD_LSB];
  assign funct   = ifid_instr_q[FN_MSB:FN_LSB];
  assign imm_ext = {{16{ifid_instr_q[IMM_MSB]}}, ifid_instr_q[IMM_MSB:IMM_LSB]};
  assign unused_c = ^{memWbEn, ifid_instr_q[10:6]};

  register_file u_rf (
    .clk   (clk),
    .rst_n (reset),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rs_val),
    .rd2_o (rt_val),
    .we_i  (wbEn),
    .wa_i  (wbDest),
    .wd_i  (wbValue)
  );

  // Control decode; anything unrecognised stays a bubble with no sources.
  always_comb begin
    ctl_alu  = ALU_ADD;
    ctl_dest = '0;
    ctl_imm  = 1'b0;
    ctl_mr   = 1'b0;
    ctl_mw   = 1'b0;
    ctl_wb   = 1'b0;
    known    = 1'b0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    case (op)
      OP_RTYPE: begin
        known = 1'b1;
        case (funct)
          FN_ADD:  ctl_alu = ALU_ADD;
          FN_SUB:  ctl_alu = ALU_SUB;
          FN_AND:  ctl_alu = ALU_AND;
          FN_OR:   ctl_alu = ALU_OR;
          FN_SLT:  ctl_alu = ALU_SLT;
          default: known = 1'b0;
        endcase
        ctl_wb   = known;
        ctl_dest = rd;
        use_rs   = known;
        use_rt   = known;
      end
      OP_ADDI: begin
        known = 1'b1; ctl_imm = 1'b1; ctl_wb = 1'b1; ctl_dest = rt; use_rs = 1'b1;
      end
      OP_LW: begin
        known = 1'b1; ctl_imm = 1'b1; ctl_mr = 1'b1; ctl_wb = 1'b1; ctl_dest = rt;
        use_rs = 1'b1;
      end
      OP_SW: begin
        known = 1'b1; ctl_imm = 1'b1; ctl_mw = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_BEQ: begin
        known = 1'b1; is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_BNE: begin
        known = 1'b1; is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // Hazards: r0 sources never match; branch also waits on EX writers and MEM loads.
  assign rs_hit_ex  = use_rs && (rs != '0) && (rs == exDest);
  assign rt_hit_ex  = use_rt && (rt != '0) && (rt == exDest);
  assign rs_hit_mem = use_rs && (rs != '0) && (rs == memDest);
  assign rt_hit_mem = use_rt && (rt != '0) && (rt == memDest);
  assign load_use_c = exMemRead && (rs_hit_ex || rt_hit_ex);
  assign br_stall_c = (is_beq || is_bne) &&
                      ((exWbEn && (rs_hit_ex || rt_hit_ex)) ||
                       (memMemRead && (rs_hit_mem || rt_hit_mem)));
  assign haz_c      = ifid_valid_q && (load_use_c || br_stall_c);
  assign br_taken_c = ifid_valid_q && !haz_c &&
                      ((is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val)));

  assign Haz_Det  = haz_c;
  assign brTaken  = br_taken_c;
  assign brOffset = imm_ext;

  // IF/ID: hold on stall, squash the wrong-path fetch on a taken branch.
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (!haz_c) begin
      if (br_taken_c) begin
        ifid_pc_d    = '0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end else begin
        ifid_pc_d    = ifPC;
        ifid_instr_d = ifInstruction;
        ifid_valid_d = 1'b1;
      end
    end
  end

  // ID/EX: stalls, branches and undecodable words all enter as an all-zero bubble.
  always_comb begin
    idex_d = IDEX_BUBBLE;
    if (ifid_valid_q && known && !haz_c && !is_beq && !is_bne) begin
      idex_d.pc        = ifid_pc_q;
      idex_d.val1      = rs_val;
      idex_d.val2      = rt_val;
      idex_d.imm_ext   = imm_ext;
      idex_d.dest      = ctl_dest;
      idex_d.alu_cmd   = ctl_alu;
      idex_d.imm_sel   = ctl_imm;
      idex_d.mem_read  = ctl_mr;
      idex_d.mem_write = ctl_mw;
      idex_d.wb_en     = ctl_wb;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      idex_q       <= IDEX_BUBBLE;
    end else begin
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      idex_q       <= idex_d;
    end
  end

  assign idPC     = idex_q.pc;
  assign val1     = idex_q.val1;
  assign val2     = idex_q.val2;
  assign immExt   = idex_q.imm_ext;
  assign dest     = idex_q.dest;
  assign aluCmd   = idex_q.alu_cmd;
  assign immSel   = idex_q.imm_sel;
  assign memRead  = idex_q.mem_read;
  assign memWrite = idex_q.mem_write;
  assign wbEnOut  = idex_q.wb_en;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, bypass, load-use and branch hazards,
// branch squash and asynchronous reset.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ifPC, ifInstruction, wbValue;
  logic        wbEn, exWbEn, exMemRead, memWbEn, memMemRead;
  logic [4:0]  wbDest, exDest, memDest;
  logic        brTaken, Haz_Det;
  logic [31:0] brOffset, idPC, val1, val2, immExt;
  logic [4:0]  dest;
  logic [3:0]  aluCmd;
  logic        immSel, memRead, memWrite, wbEnOut;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .ifPC(ifPC), .ifInstruction(ifInstruction),
    .wbEn(wbEn), .wbDest(wbDest), .wbValue(wbValue),
    .exWbEn(exWbEn), .exMemRead(exMemRead), .exDest(exDest),
    .memWbEn(memWbEn), .memMemRead(memMemRead), .memDest(memDest),
    .brTaken(brTaken), .brOffset(brOffset), .Haz_Det(Haz_Det),
    .idPC(idPC), .val1(val1), .val2(val2), .immExt(immExt), .dest(dest),
    .aluCmd(aluCmd), .immSel(immSel), .memRead(memRead), .memWrite(memWrite),
    .wbEnOut(wbEnOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd_f,
                                        input logic [4:0] rs_f, input logic [4:0] rt_f);
    return {6'h00, rs_f, rt_f, rd_f, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op_f, input logic [4:0] rs_f,
                                        input logic [4:0] rt_f, input logic [15:0] imm);
    return {op_f, rs_f, rt_f, imm};
  endfunction

  function automatic logic [31:0] ctl(input logic [3:0] a, input logic [4:0] d,
                                      input logic is, input logic mr, input logic mw,
                                      input logic wb);
    return {19'd0, a, d, is, mr, mw, wb};
  endfunction

  function automatic logic [31:0] ctl_obs();
    return {19'd0, aluCmd, dest, immSel, memRead, memWrite, wbEnOut};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr);
    ifInstruction = instr;
    step();
    ifInstruction = 32'h0;
    step();
  endtask

  task automatic wb_write(input logic [4:0] d, input logic [31:0] v);
    wbEn = 1'b1; wbDest = d; wbValue = v;
    step();
    wbEn = 1'b0;
  endtask

  task automatic quiet_inputs();
    ifPC = 32'h0; ifInstruction = 32'h0; wbEn = 1'b0; wbDest = 5'd0; wbValue = 32'h0;
    exWbEn = 1'b0; exMemRead = 1'b0; exDest = 5'd0;
    memWbEn = 1'b0; memMemRead = 1'b0; memDest = 5'd0;
  endtask

  initial begin
    reset = 1'b0;
    quiet_inputs();
    for (int i = 0; i < 5; i++) begin
      ifPC = $urandom; ifInstruction = $urandom; wbEn = 1'b1;
      wbDest = 5'($urandom_range(1, 31)); wbValue = $urandom;
      exWbEn = 1'($urandom); exMemRead = 1'($urandom); exDest = 5'($urandom);
      memWbEn = 1'($urandom); memMemRead = 1'($urandom); memDest = 5'($urandom);
      step();
    end
    check("rst_ctl", ctl_obs(), 32'h0);
    check("rst_idpc", idPC, 32'h0);
    check("rst_val1", val1, 32'h0);
    check("rst_val2", val2, 32'h0);
    check("rst_imm", immExt, 32'h0);
    check("rst_brtaken", {31'd0, brTaken}, 32'h0);
    check("rst_haz", {31'd0, Haz_Det}, 32'h0);

    quiet_inputs();
    reset = 1'b1;
    step();
    for (int i = 1; i < 32; i++) begin
      issue(rtype(6'h20, 5'd0, 5'(i), 5'(32 - i)));
      check($sformatf("zero_r%0d", i), val1 | val2, 32'h0);
    end

    // writeback bypass into ADD r3,r5,r0
    ifInstruction = rtype(6'h20, 5'd3, 5'd5, 5'd0);
    step();
    ifInstruction = 32'h0;
    wbEn = 1'b1; wbDest = 5'd5; wbValue = 32'h1234;
    step();
    wbEn = 1'b0;
    check("byp_val1", val1, 32'h1234);
    check("byp_ctl", ctl_obs(), ctl(4'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1));

    ifInstruction = rtype(6'h20, 5'd6, 5'd0, 5'd0);
    step();
    ifInstruction = 32'h0;
    wbEn = 1'b1; wbDest = 5'd0; wbValue = 32'hFFFF_FFFF;
    step();
    wbEn = 1'b0;
    check("r0_val", val1 | val2, 32'h0);
    issue(rtype(6'h25, 5'd7, 5'd5, 5'd0));
    check("r5_kept", val1, 32'h1234);
    check("or_ctl", ctl_obs(), ctl(4'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1));

    wb_write(5'd1, 32'h11);
    wb_write(5'd2, 32'h22);

    // load-use: LW r2 in EX, SUB r4,r2,r1 in IF/ID
    ifInstruction = rtype(6'h22, 5'd4, 5'd2, 5'd1);
    step();
    exMemRead = 1'b1; exDest = 5'd2;
    ifInstruction = rtype(6'h20, 5'd9, 5'd1, 5'd1);
    #1;
    check("lu_haz", {31'd0, Haz_Det}, 32'h1);
    check("lu_nobr", {31'd0, brTaken}, 32'h0);
    step();
    exMemRead = 1'b0; exDest = 5'd0;
    #1;
    check("lu_bubble", ctl_obs(), 32'h0);
    check("lu_haz_clr", {31'd0, Haz_Det}, 32'h0);
    step();
    check("lu_sub_ctl", ctl_obs(), ctl(4'd1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1));
    check("lu_sub_ops", {val1[15:0], val2[15:0]}, 32'h0022_0011);
    ifInstruction = 32'h0;
    step();
    check("lu_next", ctl_obs(), ctl(4'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1));

    // ADDI reads only rs: an EX load to its rt must not stall
    ifInstruction = itype(6'h08, 5'd1, 5'd2, 16'h0005);
    step();
    ifInstruction = 32'h0;
    exMemRead = 1'b1; exDest = 5'd2;
    #1;
    check("addi_nohaz", {31'd0, Haz_Det}, 32'h0);
    step();
    exMemRead = 1'b0; exDest = 5'd0;
    check("addi_ctl", ctl_obs(), ctl(4'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1));
    check("addi_ops", val1 ^ immExt, 32'h11 ^ 32'h5);

    // taken BEQ r1,r1,-3 squashes the wrong-path fetch
    ifInstruction = itype(6'h04, 5'd1, 5'd1, 16'hFFFD); ifPC = 32'h40;
    step();
    ifInstruction = rtype(6'h20, 5'd10, 5'd1, 5'd1); ifPC = 32'h44;
    #1;
    check("beq_taken", {31'd0, brTaken}, 32'h1);
    check("beq_off", brOffset, 32'hFFFF_FFFD);
    check("beq_nohaz", {31'd0, Haz_Det}, 32'h0);
    step();
    check("beq_onecyc", {31'd0, brTaken}, 32'h0);
    check("beq_idex", ctl_obs(), 32'h0);
    ifInstruction = 32'h0;
    step();
    check("beq_squash", ctl_obs(), 32'h0);

    ifInstruction = itype(6'h04, 5'd1, 5'd2, 16'h0008);
    step();
    ifInstruction = 32'h0;
    #1;
    check("beq_nt", {31'd0, brTaken}, 32'h0);
    check("beq_nt_off", brOffset, 32'h8);
    step();

    ifInstruction = itype(6'h04, 5'd3, 5'd1, 16'h0002);
    step();
    ifInstruction = 32'h0;
    memMemRead = 1'b1; memDest = 5'd3;
    #1;
    check("mem_ld_haz", {31'd0, Haz_Det}, 32'h1);
    memMemRead = 1'b0; memDest = 5'd0;
    #1;
    check("mem_ld_clr", {31'd0, Haz_Det}, 32'h0);
    step();

    // BNE r1,r2 waiting on an EX writer of r2, then resolved via WB bypass
    ifInstruction = itype(6'h05, 5'd1, 5'd2, 16'h0004);
    step();
    ifInstruction = 32'h0;
    exWbEn = 1'b1; exDest = 5'd2;
    #1;
    check("bne_haz", {31'd0, Haz_Det}, 32'h1);
    check("bne_hold", {31'd0, brTaken}, 32'h0);
    step();
    exWbEn = 1'b0; exDest = 5'd0;
    wbEn = 1'b1; wbDest = 5'd2; wbValue = 32'h11;
    #1;
    check("bne_haz_clr", {31'd0, Haz_Det}, 32'h0);
    check("bne_byp_eq", {31'd0, brTaken}, 32'h0);
    wbValue = 32'h33;
    #1;
    check("bne_byp_ne", {31'd0, brTaken}, 32'h1);
    wbValue = 32'h11;
    step();
    wbEn = 1'b0;

    ifPC = 32'h100;
    issue(itype(6'h23, 5'd1, 5'd8, 16'h0004));
    check("lw_ctl", ctl_obs(), ctl(4'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1));
    check("lw_imm", immExt, 32'h4);
    check("lw_pc", idPC, 32'h100);
    issue(itype(6'h2B, 5'd1, 5'd2, 16'hFFF8));
    check("sw_ctl", ctl_obs(), ctl(4'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    check("sw_imm", immExt, 32'hFFFF_FFF8);
    check("sw_val2", val2, 32'h11);
    issue(rtype(6'h24, 5'd5, 5'd1, 5'd2));
    check("and_ctl", ctl_obs(), ctl(4'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(rtype(6'h2A, 5'd6, 5'd1, 5'd2));
    check("slt_ctl", ctl_obs(), ctl(4'd4, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(itype(6'h3F, 5'd1, 5'd2, 16'h0007));
    check("badop_ctl", ctl_obs(), 32'h0);
    issue(rtype(6'h21, 5'd7, 5'd1, 5'd2));
    check("badfn_ctl", ctl_obs(), 32'h0);

    // reset pulsed while a taken branch sits in IF/ID
    ifPC = 32'h200;
    ifInstruction = rtype(6'h20, 5'd12, 5'd1, 5'd1);
    step();
    ifInstruction = itype(6'h04, 5'd1, 5'd1, 16'h0002);
    step();
    ifInstruction = 32'h0;
    check("mid_br", {31'd0, brTaken}, 32'h1);
    check("mid_add", ctl_obs(), ctl(4'd0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1));
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_br", {31'd0, brTaken}, 32'h0);
    check("mid_rst_ctl", ctl_obs(), 32'h0);
    check("mid_rst_val", val1 | idPC, 32'h0);
    step();
    step();
    reset = 1'b1;
    ifInstruction = rtype(6'h20, 5'd13, 5'd1, 5'd2);
    step();
    ifInstruction = 32'h0;
    step();
    check("post_rst_ctl", ctl_obs(), ctl(4'd0, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1));
    check("post_rst_regs", val1 | val2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
